// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI3 response/burst constants, FSM states and address helper
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // WRAP is deliberately treated as INCR; only FIXED holds the address.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// rtl/axi_sram_mem.sv - byte-enabled 32-bit register array, one write port, one async read port
module axi_sram_mem #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 32-bit slave backed by word SRAM; optional trace via AXI_SRAM_TRACE_EN
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [11:0] wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [11:0] bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [11:0] arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [11:0] rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int IDX_W = $clog2(DEPTH);

  wstate_t     wstate;
  rstate_t     rstate;
  logic [31:0] waddr_q, raddr_q, r_next;
  logic [3:0]  wlen_q, wbeat_q, rlen_q, rbeat_q;
  logic [1:0]  wburst_q, rburst_q;
  logic        w_fire, w_end;
  logic [IDX_W-1:0] mem_raddr;
  logic [31:0] mem_rdata;

  assign w_fire = wready && wvalid;
  assign w_end  = wlast || (wbeat_q == wlen_q);
  assign r_next = next_addr(raddr_q, rburst_q);

  // Idle reads straight from the AR address so the first beat is ready one cycle after accept.
  assign mem_raddr = (rstate == R_IDLE) ? araddr[IDX_W+1:2] : r_next[IDX_W+1:2];

  axi_sram_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk   (clk),
    .we    (w_fire),
    .waddr (waddr_q[IDX_W+1:2]),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate   <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wbeat_q  <= '0;
      wburst_q <= BURST_INCR;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (awready && awvalid) begin
            awready  <= 1'b0;
            wready   <= 1'b1;
            bid      <= awid;
            waddr_q  <= awaddr;
            wlen_q   <= awlen;
            wbeat_q  <= '0;
            wburst_q <= awburst;
            wstate   <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            waddr_q <= next_addr(waddr_q, wburst_q);
            wbeat_q <= wbeat_q + 4'd1;
            if (w_end) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              // OKAY only when wlast lands exactly on the final beat
              bresp  <= (wlast && (wbeat_q == wlen_q)) ? RESP_OKAY : RESP_SLVERR;
              wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate   <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rbeat_q  <= '0;
      rburst_q <= BURST_INCR;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arready && arvalid) begin
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rid      <= arid;
            rdata    <= mem_rdata;
            rresp    <= RESP_OKAY;
            rlast    <= (arlen == 4'd0);
            raddr_q  <= araddr;
            rlen_q   <= arlen;
            rbeat_q  <= '0;
            rburst_q <= arburst;
            rstate   <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              raddr_q <= r_next;
              rdata   <= mem_rdata;
              rbeat_q <= rbeat_q + 4'd1;
              rlast   <= ((rbeat_q + 4'd1) == rlen_q);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{awsize, arsize, wid, araddr[31:IDX_W+2], araddr[1:0],
                         waddr_q[31:IDX_W+2], waddr_q[1:0], raddr_q[31:IDX_W+2], raddr_q[1:0]};

`ifdef AXI_SRAM_TRACE_EN
  always_ff @(posedge clk) begin
    if (w_fire)
      $display("axi_sram wr idx=%0d data=%h strb=%b", waddr_q[IDX_W+1:2], wdata, wstrb);
    if (bvalid && bready)
      $display("axi_sram B id=%h resp=%b", bid, bresp);
    if (rvalid && rready && rlast)
      $display("axi_sram R id=%h resp=%b", rid, rresp);
  end
`endif

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized self-checking bench for axi_sram_slave
module tb_axi_sram_slave;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] awid, wid, bid, arid, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awlen, wstrb, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, bresp, arburst, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_q [16];
  logic [1:0]  got_bresp;

  axi_sram_slave #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  function automatic int unsigned word_of(input logic [31:0] addr, input int beat, input logic [1:0] burst);
    return ((addr / 4) + ((burst == 2'b00) ? 0 : beat)) % DEPTH;
  endfunction

  task automatic do_write(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input int last_beat, input int bdelay);
    int n, nb, stalls;
    int unsigned idx;
    logic [1:0] exp_resp;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!awready) begin
      errors++; $display("FAIL aw_timeout awready=%b required 1", awready);
      awvalid = 1'b0; return;
    end
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if (wready !== 1'b1) begin errors++; $display("FAIL wready_latency got %b required 1", wready); end
    nb = (last_beat < int'(len)) ? last_beat + 1 : int'(len) + 1;
    stalls = 0;
    for (int i = 0; i < nb; i++) begin
      wid = id; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_beat); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      stalls += n;
      if (!wready) begin
        checks++; errors++; $display("FAIL w_timeout beat=%0d wready=%b required 1", i, wready);
        wvalid = 1'b0; return;
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL w_stall stalls=%0d required 0", stalls); end
    for (int i = 0; i < nb; i++) begin
      idx = word_of(addr, i, burst);
      for (int b = 0; b < 4; b++)
        if (ws[i][b]) ref_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
    end
    exp_resp = (last_beat == int'(len)) ? 2'b00 : 2'b10;
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL b_latency bvalid=%b required 1", bvalid); end
    for (int d = 0; d < bdelay; d++) begin
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        errors++; $display("FAIL b_hold bvalid=%b awready=%b required 1 0", bvalid, awready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    got_bresp = bresp;
    checks++;
    if (bvalid !== 1'b1 || bid !== id || bresp !== exp_resp) begin
      errors++;
      $display("FAIL b_resp bvalid=%b bid=%h bresp=%b required 1 %h %b", bvalid, bid, bresp, id, exp_resp);
    end
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      errors++; $display("FAIL b_done awready=%b bvalid=%b required 1 0", awready, bvalid);
    end
  endtask

  task automatic do_read(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int stall_beat, input int stall_cyc);
    int n;
    logic [31:0] hold;
    logic [31:0] exp;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!arready) begin
      errors++; $display("FAIL ar_timeout arready=%b required 1", arready);
      arvalid = 1'b0; return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL r_latency rvalid=%b required 1", rvalid); end
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        rready = 1'b0;
        hold = rdata;
        for (int k = 0; k < stall_cyc; k++) begin
          @(negedge clk);
          checks++;
          if (rvalid !== 1'b1 || rdata !== hold || rlast !== (i == int'(len)) || rid !== id) begin
            errors++;
            $display("FAIL r_stall beat=%0d rdata=%h rlast=%b rid=%h required %h %b %h",
                     i, rdata, rlast, rid, hold, (i == int'(len)), id);
          end
        end
      end
      rready = 1'b1;
      n = 0;
      while (!rvalid && n < 100) begin @(negedge clk); n++; end
      exp = ref_mem[word_of(addr, i, burst)];
      rd_q[i] = rdata;
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp || rlast !== (i == int'(len)) || rid !== id || rresp !== 2'b00) begin
        errors++;
        $display("FAIL r_beat beat=%0d rdata=%h rlast=%b rid=%h rresp=%b required %h %b %h 00",
                 i, rdata, rlast, rid, rresp, exp, (i == int'(len)), id);
      end
      @(negedge clk);
    end
    rready = 1'b0;
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++; $display("FAIL r_done arready=%b rvalid=%b required 1 0", arready, rvalid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 ||
        bresp !== 2'b0 || rresp !== 2'b0 || bid !== 12'h0 || rid !== 12'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_values aw=%b w=%b b=%b ar=%b r=%b rl=%b bresp=%b rresp=%b bid=%h rid=%h rdata=%h required all 0",
               awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errors++; $display("FAIL reset_release awready=%b arready=%b required 1 1", awready, arready);
    end
  endtask

  task automatic test_incr;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11111111 * (i + 1); ws[i] = 4'hF; end
    do_write(12'hABC, 32'h0, 4'd3, 2'b01, 3, 0);
    do_read(12'h123, 32'h0, 4'd3, 2'b01, 99, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== 32'h11111111 * (i + 1)) begin
        errors++; $display("FAIL incr_data beat=%0d got %h required %h", i, rd_q[i], 32'h11111111 * (i + 1));
      end
    end
  endtask

  task automatic test_strobe;
    wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
    do_write(12'h1, 32'h10, 4'd0, 2'b01, 0, 0);
    wd[0] = 32'h0; ws[0] = 4'b0101;
    do_write(12'h2, 32'h10, 4'd0, 2'b01, 0, 0);
    do_read(12'h3, 32'h10, 4'd0, 2'b01, 99, 0);
    checks++;
    if (rd_q[0] !== 32'hAA00CC00) begin
      errors++; $display("FAIL strobe_merge got %h required AA00CC00", rd_q[0]);
    end
  endtask

  task automatic test_early_wlast;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hDEAD0000 + i; ws[i] = 4'hF; end
    do_write(12'h10, 32'h0, 4'd3, 2'b01, 3, 0);
    for (int i = 0; i < 4; i++) wd[i] = 32'h55550000 + i;
    do_write(12'h11, 32'h0, 4'd3, 2'b01, 1, 0);
    checks++;
    if (got_bresp !== 2'b10) begin errors++; $display("FAIL early_wlast_resp got %b required 10", got_bresp); end
    do_read(12'h12, 32'h0, 4'd3, 2'b01, 99, 0);
    checks++;
    if (rd_q[1] !== 32'h55550001 || rd_q[2] !== 32'hDEAD0002 || rd_q[3] !== 32'hDEAD0003) begin
      errors++;
      $display("FAIL early_wlast_mem got %h %h %h required 55550001 DEAD0002 DEAD0003", rd_q[1], rd_q[2], rd_q[3]);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(12'h20, 32'h40, 4'd7, 2'b01, 7, 5);
    do_read(12'h21, 32'h40, 4'd7, 2'b01, 3, 4);
    do_read(12'h22, 32'h40, 4'd7, 2'b10, 0, 2);
  endtask

  task automatic test_fixed_alias;
    for (int i = 0; i < 3; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    do_write(12'h30, 32'h20, 4'd2, 2'b00, 2, 0);
    do_read(12'h31, 32'h20, 4'd0, 2'b01, 99, 0);
    checks++;
    if (rd_q[0] !== 32'h3) begin errors++; $display("FAIL fixed_last got %h required 3", rd_q[0]); end
    wd[0] = 32'h00000077; ws[0] = 4'hF;
    do_write(12'h32, DEPTH * 4, 4'd0, 2'b01, 0, 0);
    do_read(12'h33, 32'h0, 4'd0, 2'b01, 99, 0);
    checks++;
    if (rd_q[0] !== 32'h77) begin errors++; $display("FAIL alias_word0 got %h required 77", rd_q[0]); end
  endtask

  task automatic test_random;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [31:0] addr;
    int last_beat;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(12'(w), 32'(w * 64), 4'd15, 2'b01, 15, 0);
    end
    for (int t = 0; t < 40; t++) begin
      len   = 4'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 2));
      addr  = 32'(($urandom_range(0, 15) << 12) | ($urandom_range(0, 47) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        last_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'(len);
        do_write(12'($urandom), addr, len, burst, last_beat, int'($urandom_range(0, 2)));
      end else begin
        do_read(12'($urandom), addr, len, burst, int'($urandom_range(0, 18)), int'($urandom_range(1, 3)));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
    test_reset;
    test_incr;
    test_strobe;
    test_early_wlast;
    test_backpressure;
    test_fixed_alias;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
